// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the handshaked ALU (alu_pipe) and its
// iterative multiplier (alu_mul_iter).
//   alu_op_e    : 4-bit opcode carried on the alu_pipe op port
//   alu_state_e : control FSM states of alu_pipe
//   sext()      : sign-extend the low w bits of a vector to MAX_W bits
// ---------------------------------------------------------------------------
package alu_pkg;

  // Widest result the helper function can produce; alu_pipe results are
  // 2*WIDTH bits, so WIDTH must stay at or below MAX_W/2.
  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_OR      = 4'd3,
    OP_XOR     = 4'd4,
    OP_NAND    = 4'd5,
    OP_NOR     = 4'd6,
    OP_XNOR    = 4'd7,
    OP_INC_A   = 4'd8,
    OP_DEC_A   = 4'd9,
    OP_INC_B   = 4'd10,
    OP_DEC_B   = 4'd11,
    OP_MUL     = 4'd12,
    OP_ACC_ADD = 4'd13,
    OP_ACC_CLR = 4'd14,
    OP_ILLEGAL = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    HOLD    = 2'd2
  } alu_state_e;

  // Shift the w-bit field to the top, then arithmetic-shift it back down so
  // bit w-1 is replicated into every upper bit. Callers truncate the result
  // to their own width.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v,
                                            input int w);
    logic signed [MAX_W-1:0] t;
    t = $signed(v << (MAX_W - w));
    return t >>> (MAX_W - w);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative signed multiplier: shift-add on operand magnitudes, one
// multiplier bit per cycle for WIDTH cycles, sign applied at the end.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort, clears all iteration state
//   start      : load A/B and begin (ignored while flush is high)
//   A, B       : WIDTH-bit signed operands
//   done       : one-cycle pulse in the cycle the final product is valid
//   product    : exact signed product, 2*WIDTH bits, valid while done=1
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int OUT_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [OUT_W-1:0] partial_q, partial_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [OUT_W-1:0] stepSum;

  // The most negative operand has magnitude 2^(WIDTH-1), which still fits
  // in WIDTH unsigned bits, so no extra bit is needed here.
  assign magA = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign magB = B[WIDTH-1] ? (~B + 1'b1) : B;

  // The last addition is folded into the output combinationally so the
  // product is ready in the same cycle the counter reaches zero.
  assign stepSum = partial_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == '0) && !flush;
  assign product = neg_q ? ('0 - stepSum) : stepSum;

  // Iteration control: load on start, then one shift-add per cycle while
  // counting down from WIDTH-1 to 0.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    neg_d     = neg_q;
    if (flush) begin
      busy_d    = 1'b0;
      cnt_d     = '0;
      mcand_d   = '0;
      mplier_d  = '0;
      partial_d = '0;
      neg_d     = 1'b0;
    end else if (start) begin
      busy_d    = 1'b1;
      cnt_d     = CNT_W'(WIDTH - 1);
      mcand_d   = OUT_W'(magA);
      mplier_d  = magB;
      partial_d = '0;
      neg_d     = A[WIDTH-1] ^ B[WIDTH-1];
    end else if (busy_q) begin
      partial_d = stepSum;
      mcand_d   = mcand_q << 1;
      mplier_d  = mplier_q >> 1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      neg_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      neg_q     <= neg_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Handshaked signed/logical ALU with an iterative multiplier, an internal
// accumulator and per-result error/overflow flags. One operation in flight.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous abort of in-flight op / held result
//   in_valid, in_ready  : operand handshake (accept when both high)
//   A, B                : WIDTH-bit signed operands
//   op                  : opcode (alu_pkg::alu_op_e)
//   out_valid, out_ready: result handshake, result held until out_ready
//   C                   : 2*WIDTH-bit result
//   error_flag          : illegal opcode for this result
//   ovf                 : accumulator signed wrap for this result
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [3:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   C,
  output logic                 error_flag,
  output logic                 ovf
);

  localparam int OUT_W = 2 * WIDTH;

  alu_state_e       state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] c_q, c_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  alu_op_e          opCode;
  logic             accept;
  logic             startMul;
  logic             mulDone;
  logic [OUT_W-1:0] mulProduct;
  logic [OUT_W-1:0] sextA;
  logic [OUT_W-1:0] sextB;
  logic [OUT_W-1:0] accSum;
  logic [WIDTH-1:0] logicRes;
  logic [OUT_W-1:0] aluRes;
  logic             aluErr;
  logic             aluOvf;
  logic [OUT_W-1:0] accNext;

  assign opCode   = alu_op_e'(op);
  assign accept   = in_valid && in_ready;
  assign startMul = accept && (opCode == OP_MUL);

  assign sextA  = OUT_W'(sext(MAX_W'(A), WIDTH));
  assign sextB  = OUT_W'(sext(MAX_W'(B), WIDTH));
  assign accSum = acc_q + sextA;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (startMul),
    .A      (A),
    .B      (B),
    .done   (mulDone),
    .product(mulProduct)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A multiply always detours through MUL_RUN; every
  // other accepted op lands straight in HOLD.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = (opCode == OP_MUL) ? MUL_RUN : HOLD;
          end
        end
        MUL_RUN: begin
          if (mulDone) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (accept) begin
              state_d = (opCode == OP_MUL) ? MUL_RUN : HOLD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs. In HOLD a new op is taken only when the current
  // result leaves in the same cycle, so nothing is overwritten unseen.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !flush;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !flush;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Single-cycle result for every opcode except MUL. Arithmetic is done on
  // sign-extended operands at full result width, so it cannot overflow.
  always_comb begin
    aluRes   = '0;
    aluErr   = 1'b0;
    aluOvf   = 1'b0;
    accNext  = acc_q;
    logicRes = '0;
    case (opCode)
      OP_ADD:   aluRes = sextA + sextB;
      OP_SUB:   aluRes = sextA - sextB;
      OP_AND:   begin logicRes = A & B;    aluRes = OUT_W'(logicRes); end
      OP_OR:    begin logicRes = A | B;    aluRes = OUT_W'(logicRes); end
      OP_XOR:   begin logicRes = A ^ B;    aluRes = OUT_W'(logicRes); end
      OP_NAND:  begin logicRes = ~(A & B); aluRes = OUT_W'(logicRes); end
      OP_NOR:   begin logicRes = ~(A | B); aluRes = OUT_W'(logicRes); end
      OP_XNOR:  begin logicRes = ~(A ^ B); aluRes = OUT_W'(logicRes); end
      OP_INC_A: aluRes = sextA + 1'b1;
      OP_DEC_A: aluRes = sextA - 1'b1;
      OP_INC_B: aluRes = sextB + 1'b1;
      OP_DEC_B: aluRes = sextB - 1'b1;
      OP_ACC_ADD: begin
        accNext = accSum;
        aluRes  = accSum;
        // Wrap happened if both addends share a sign the sum does not.
        aluOvf  = (acc_q[OUT_W-1] == sextA[OUT_W-1]) &&
                  (accSum[OUT_W-1] != acc_q[OUT_W-1]);
      end
      OP_ACC_CLR: begin
        accNext = '0;
        aluRes  = '0;
      end
      OP_ILLEGAL: aluErr = 1'b1;
      default: aluRes = '0;
    endcase
  end

  // Result/accumulator update: only on an edge that enters HOLD, so C and
  // the flags stay frozen under backpressure and across a flush.
  always_comb begin
    c_d   = c_q;
    err_d = err_q;
    ovf_d = ovf_q;
    acc_d = acc_q;
    if (accept && (opCode != OP_MUL)) begin
      c_d   = aluRes;
      err_d = aluErr;
      ovf_d = aluOvf;
      acc_d = accNext;
    end else if ((state_q == MUL_RUN) && mulDone) begin
      c_d   = mulProduct;
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      acc_q <= '0;
    end else begin
      c_q   <= c_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
      acc_q <= acc_d;
    end
  end

  assign C          = c_q;
  assign error_flag = err_q;
  assign ovf        = ovf_q;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 5-bit ALU: signed/logical ALU with valid/ready flow control on both sides, an iterative multi-cycle multiplier, an internal accumulator and a per-result error/overflow indication. It sits between an operand source (sequencer or bus adapter) and a result sink, and replaces the enable-strobe ALU in new datapaths. Only one operation is in flight at a time.

## Interface
- WIDTH, 5: operand width in bits, two's-complement signed, WIDTH ≥ 3.
- OUT_W, 2*WIDTH: result and accumulator width; derived, not to be overridden.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the in-flight operation and any held result; accumulator is kept.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block accepts when in_valid && in_ready.
- A, B  in  WIDTH  signed operands.
- op  in  4  opcode (alu_pkg::alu_op_e).
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  sink accepts the result.
- C  out  OUT_W  result.
- error_flag  out  1  illegal opcode for this result.
- ovf  out  1  signed wrap of the accumulator for this result.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR, 7 XNOR, 8 INC_A, 9 DEC_A, 10 INC_B, 11 DEC_B, 12 MUL, 13 ACC_ADD, 14 ACC_CLR, 15 illegal.
- Arithmetic ops (ADD/SUB/INC/DEC) are exact: sign-extend to OUT_W, compute, no overflow possible.
- Logic ops act on WIDTH bits and zero-extend to OUT_W.
- MUL: exact signed product A*B in OUT_W. Computed iteratively (shift-add on magnitudes, sign fixed at end), WIDTH iterations.
- ACC_ADD: acc ← acc + sext(A), modulo 2^OUT_W. C = new acc. ovf=1 iff the signed sum wrapped.
- ACC_CLR: acc ← 0, C = 0.
- Illegal op: C = 0, error_flag = 1, acc unchanged.
- error_flag and ovf are 0 for every other result. Both are valid only while out_valid=1.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - MUL_RUN: counter from WIDTH-1 down to 0, in_ready=0, out_valid=0.
  - HOLD: out_valid=1, in_ready=out_ready.
- Transitions:
  - IDLE, accept non-MUL → HOLD. IDLE, accept MUL → MUL_RUN.
  - MUL_RUN, count 0 → HOLD.
  - HOLD, out_ready && !(in_valid) → IDLE.
  - HOLD, out_ready && in_valid → HOLD with the new non-MUL result, or → MUL_RUN for MUL.
  - HOLD, !out_ready → HOLD with C/flags stable.
- flush: next state IDLE from any state. out_valid is 0 the following cycle. A handshake on the flush cycle is ignored, and in_ready is 0 while flush=1.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, C 0, error_flag 0, ovf 0, acc 0, iteration counter 0.
- Latency, non-MUL: accepted at edge N → out_valid=1 after edge N (visible in cycle N+1).
- Latency, MUL: out_valid visible in cycle N+WIDTH+1.
- Throughput: one non-MUL result per cycle when out_ready is held high.
- C, error_flag and ovf change only on a HOLD-entry edge. They are stable while out_valid && !out_ready.
- Reset asserted mid-MUL or in HOLD: immediate return to reset values, and the result is lost.
- Back-to-back ACC_ADD: each operation sees the acc updated by the previous one.

## Structure
- alu_pkg holds:
  - alu_op_e (4-bit opcode enum).
  - alu_state_e {IDLE, MUL_RUN, HOLD}.
  - function sext(WIDTH→OUT_W).
- Sub-module alu_mul_iter(WIDTH), instantiated once:
  - Inputs: start, A, B.
  - Outputs: done (one-cycle pulse), product[OUT_W-1:0].
  - Control: cleared by rst_n and flush.
- Top: FSM, logic/arith combinational unit, accumulator, output register.

## Test plan
1. ADD, 15 + 1 with out_ready=1 → C=16 (0x010) in cycle N+1, error_flag=0, ovf=0. SUB, -16 - 15 → C=-31 (0x3E1).
2. MUL, -16 * -16 → out_valid first at N+6, C=256 (0x100). in_ready stays 0 for cycles N+1..N+5. MUL 15 * -1 → C=-15.
3. op=15 with A=7, B=3 → C=0, error_flag=1. The next ADD result shows error_flag=0.
4. Backpressure: XOR 0x0A,0x1F accepted, out_ready=0 for 3 cycles → C=0x015 held, in_ready=0. out_ready=1 with a new op → next result the following cycle, nothing dropped or duplicated.
5. Accumulator:
   - ACC_CLR, then ACC_ADD A=15 ×34 → C=510, ovf=0.
   - 35th ACC_ADD → C=-499 (0x20D), ovf=1.
   - ACC_CLR → C=0.
6. Abort:
   - MUL accepted, rst_n low at N+3 → all outputs at reset values, in_ready=1. After release, ADD 1+1 → C=2.
   - Repeat with flush at N+3 → out_valid never rises for the MUL, acc unchanged.
